b1_loc_gen: RTL and testbench
=============================

B1_LOC_GEN -- requirements
Module: b1_loc_gen

Interface
REQ-001 SHALL have ports: rx_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rx_rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: rx_enable  in  1  high = generator runs; low = all state frozen.
REQ-004 SHALL have ports: rx_load  in  1  one-cycle pulse, restarts epoch and samples taps.
REQ-005 SHALL have ports: rx_g2_tapA, rx_g2_tapB  in  4 each  G2 phase-select stage indices 1..11.
REQ-006 SHALL have ports: rx_prn_fcw  in  32  code NCO frequency control word, half-chip rate = fcw/2^32 * f_clk.
REQ-007 SHALL have ports: tx_loc_bocE, tx_loc_bocP, tx_loc_bocL  out  1 each  local replica, 1 = negate sample.
REQ-008 SHALL have ports: tx_prn_sop  out  1  one-cycle pulse, P replica starts a new code epoch.
REQ-009 SHALL have ports: tx_chip_cnt  out  11  chip index 0..2045 currently on the P replica.

Function
REQ-010 SHALL accumulate rx_prn_fcw into a 32-bit phase register every enabled cycle; carry-out = half-chip tick.
REQ-011 SHALL generate code via G1 = 1+x+x^7+x^8+x^9+x^10+x^11 and G2 = 1+x+x^2+x^3+x^4+x^5+x^8+x^9+x^11, both initialised to 01010101010 (stages 1..11).
REQ-012 SHALL form code chip = G1[11] XOR G2[tapA] XOR G2[tapB], with taps latched on rx_load.
REQ-013 SHALL step LFSRs and the chip counter on every second tick (end of half 1); half index toggles every tick.
REQ-014 SHALL truncate the epoch at 2046 chips: on the tick ending chip 2045 half 1, reload both LFSRs to the initial state and set the chip counter to 0.
REQ-015 SHALL compute the new half-chip value = chip XOR half (BOC(1,1)) and, on each tick, shift it into a 3-bit register: E = newest, P = middle, L = oldest (±0.5 chip spacing).
REQ-016 SHALL shift an epoch-start marker (chip 0, half 0) and the chip index through the same pipeline; tx_prn_sop = 1 for exactly the cycle after the edge on which the marker reaches P; tx_chip_cnt follows P.
REQ-017 SHALL register all outputs; E/P/L change only on the clock edge of a tick.
REQ-018 SHALL, on rx_load, on the next edge clear the phase to 0, reload LFSRs, set chip/half to 0 and clear the E/P/L and marker pipelines; rx_load wins over a simultaneous tick.
REQ-019 SHALL, with rx_enable low, hold phase, LFSRs, pipelines and outputs, and force tx_prn_sop to 0; rx_load is honoured regardless of rx_enable.
REQ-020 SHALL treat fcw = 0 as no ticks (outputs constant) and accept any fcw up to 0xFFFFFFFF (one tick at most per cycle).
REQ-021 SHALL treat tap values 0 or >11 as 11.

Reset
REQ-022 SHALL on rx_rst_n low set phase 0, LFSRs 01010101010, chip/half 0, taps 1 and 3, E/P/L/marker pipelines 0, all outputs 0.
REQ-023 SHALL resume on the first edge after rx_rst_n release; reset mid-epoch discards all progress.

Configuration
REQ-024 SHALL with B1_LOC_BPSK_EN defined force the subcarrier term to 0 (BPSK(2), replica = code only); without it, BOC(1,1) per REQ-015.

Structure
REQ-025 SHALL place the LFSR widths, initial state, epoch length 2046 and default taps in shared package b1_trk_pkg.
REQ-026 SHALL implement the Gold generator (LFSRs, taps, truncation) as sub-module b1_gold_gen, stepped by an enable.

Verification
REQ-027 SHALL cover: fcw = 0x80000000, taps 1/3 -> tick every 2 cycles, tx_prn_sop period 8184 cycles, tx_chip_cnt wraps 2045 -> 0.
REQ-028 SHALL cover: fcw = 0x80000000 -> P equals E delayed 2 cycles, L equals E delayed 4 cycles, bit-exact over one epoch.
REQ-029 SHALL cover: BOC build, any chip -> E shows value x then ~x over the two halves; BPSK build -> both halves equal.
REQ-030 SHALL cover: first 2046 P chips for taps 1/3 match the golden model; first G1 output bit = 0.
REQ-031 SHALL cover: rx_load coincident with tick at chip 1000 -> next cycle chip 0, phase 0, no tick taken.
REQ-032 SHALL cover: rx_enable low 100 cycles mid-epoch -> outputs frozen, sop 0; sequence resumes without chip slip.

Source files
------------

// File: rtl/b1_trk_pkg.sv
// ---------------------------------------------------------------------------
// b1_trk_pkg -- shared constants and types for the B1 local code generator.
//
// Contents:
//   LFSR_W / LFSR_INIT   Gold LFSR width and initial state (stages 1..11)
//   EPOCH_LEN            truncated code length in chips
//   TAP_*                G2 phase-select width and default taps (1 and 3)
//   half_chip_t          one entry of the E/P/L replica pipeline
//   sanitize_tap()       maps illegal tap values (0, >11) to stage 11
// ---------------------------------------------------------------------------
package b1_trk_pkg;

    localparam int unsigned LFSR_W    = 11;
    localparam int unsigned CHIP_W    = 11;
    localparam int unsigned TAP_W     = 4;
    localparam int unsigned EPOCH_LEN = 2046;

    // Stage i lives in bit i; stages 1..11 = 0,1,0,1,0,1,0,1,0,1,0.
    localparam logic [LFSR_W:1]    LFSR_INIT     = 11'b01010101010;
    localparam logic [CHIP_W-1:0]  CHIP_LAST     = CHIP_W'(EPOCH_LEN - 1);
    localparam logic [TAP_W-1:0]   TAP_A_DEFAULT = 4'd1;
    localparam logic [TAP_W-1:0]   TAP_B_DEFAULT = 4'd3;

    // Newest replica sample plus the bookkeeping that travels with it.
    typedef struct packed {
        logic              val;     // 1 = negate sample
        logic              marker;  // chip 0, half 0 of an epoch
        logic [CHIP_W-1:0] chip;    // chip index of this sample
    } half_chip_t;

    function automatic logic [TAP_W-1:0] sanitize_tap(input logic [TAP_W-1:0] tap);
        return ((tap == '0) || (tap > 4'd11)) ? 4'd11 : tap;
    endfunction

endpackage

// File: rtl/b1_gold_gen.sv
// ---------------------------------------------------------------------------
// b1_gold_gen -- truncated Gold code generator (G1/G2 LFSRs + phase selector).
//
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   load_i           restart the epoch and latch the taps (wins over step_i)
//   step_i           advance one chip
//   tap_a_i, tap_b_i G2 phase-select stage indices (sanitised when latched)
//   chip_o           current code chip = G1[11] ^ G2[tapA] ^ G2[tapB]
//   chip_idx_o       index of the current chip, 0..EPOCH_LEN-1
// ---------------------------------------------------------------------------
module b1_gold_gen
    import b1_trk_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [TAP_W-1:0]  tap_a_i,
    input  logic [TAP_W-1:0]  tap_b_i,
    output logic              chip_o,
    output logic [CHIP_W-1:0] chip_idx_o
);

    logic [LFSR_W:1]   g1_q, g1_d;
    logic [LFSR_W:1]   g2_q, g2_d;
    logic [TAP_W-1:0]  tap_a_q, tap_a_d;
    logic [TAP_W-1:0]  tap_b_q, tap_b_d;
    logic [CHIP_W-1:0] idx_q, idx_d;
    logic              g1_fb;
    logic              g2_fb;

    // Fibonacci feedback from the polynomial stages into stage 1.
    assign g1_fb = g1_q[1] ^ g1_q[7] ^ g1_q[8] ^ g1_q[9] ^ g1_q[10] ^ g1_q[11];
    assign g2_fb = g2_q[1] ^ g2_q[2] ^ g2_q[3] ^ g2_q[4] ^ g2_q[5]
                 ^ g2_q[8] ^ g2_q[9] ^ g2_q[11];

    always_comb begin
        g1_d    = g1_q;
        g2_d    = g2_q;
        tap_a_d = tap_a_q;
        tap_b_d = tap_b_q;
        idx_d   = idx_q;
        if (load_i) begin
            g1_d    = LFSR_INIT;
            g2_d    = LFSR_INIT;
            idx_d   = '0;
            tap_a_d = sanitize_tap(tap_a_i);
            tap_b_d = sanitize_tap(tap_b_i);
        end else if (step_i) begin
            if (idx_q == CHIP_LAST) begin
                // Truncated epoch: the natural 2047-chip sequence is cut short.
                g1_d  = LFSR_INIT;
                g2_d  = LFSR_INIT;
                idx_d = '0;
            end else begin
                g1_d  = {g1_q[LFSR_W-1:1], g1_fb};
                g2_d  = {g2_q[LFSR_W-1:1], g2_fb};
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            g1_q    <= LFSR_INIT;
            g2_q    <= LFSR_INIT;
            tap_a_q <= TAP_A_DEFAULT;
            tap_b_q <= TAP_B_DEFAULT;
            idx_q   <= '0;
        end else begin
            g1_q    <= g1_d;
            g2_q    <= g2_d;
            tap_a_q <= tap_a_d;
            tap_b_q <= tap_b_d;
            idx_q   <= idx_d;
        end
    end

    // Taps are always 1..11 after sanitising, so the selects stay in range.
    assign chip_o     = g1_q[LFSR_W] ^ g2_q[tap_a_q] ^ g2_q[tap_b_q];
    assign chip_idx_o = idx_q;

endmodule

// File: rtl/b1_loc_gen.sv
// ---------------------------------------------------------------------------
// b1_loc_gen -- B1 local replica generator: code NCO, truncated Gold code,
// BOC(1,1) subcarrier and Early/Prompt/Late half-chip pipeline.
//
// Ports:
//   rx_clk, rx_rst_n          clock, asynchronous active-low reset
//   rx_enable                 1 = run, 0 = freeze all state (sop forced 0)
//   rx_load                   restart epoch, clear phase/pipelines, latch taps
//   rx_g2_tapA, rx_g2_tapB    G2 phase-select stages (0 or >11 treated as 11)
//   rx_prn_fcw                code NCO word; carry-out = half-chip tick
//   tx_loc_bocE/P/L           replica samples, 1 = negate; half-chip spaced
//   tx_prn_sop                one-cycle pulse when P starts a new epoch
//   tx_chip_cnt               chip index currently on P
//
// Build option: define B1_LOC_BPSK_EN to drop the subcarrier (replica = code).
// ---------------------------------------------------------------------------
module b1_loc_gen
    import b1_trk_pkg::*;
(
    input  logic              rx_clk,
    input  logic              rx_rst_n,
    input  logic              rx_enable,
    input  logic              rx_load,
    input  logic [TAP_W-1:0]  rx_g2_tapA,
    input  logic [TAP_W-1:0]  rx_g2_tapB,
    input  logic [31:0]       rx_prn_fcw,
    output logic              tx_loc_bocE,
    output logic              tx_loc_bocP,
    output logic              tx_loc_bocL,
    output logic              tx_prn_sop,
    output logic [CHIP_W-1:0] tx_chip_cnt
);

    logic [31:0]       phase_q, phase_d;
    logic [31:0]       phase_sum;
    logic              carry;
    logic              tick;
    logic              half_q, half_d;
    logic              sub_term;
    logic              code_chip;
    logic [CHIP_W-1:0] chip_idx;
    half_chip_t        e_q, e_d;
    half_chip_t        new_sample;
    logic              p_val_q, p_val_d;
    logic [CHIP_W-1:0] p_chip_q, p_chip_d;
    logic              l_val_q, l_val_d;
    logic              sop_q, sop_d;

    assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, rx_prn_fcw};

    // A load on the same edge as a carry suppresses the tick entirely.
    assign tick = rx_enable & carry & ~rx_load;

`ifdef B1_LOC_BPSK_EN
    assign sub_term = 1'b0;
`else
    assign sub_term = half_q;
`endif

    // The code advances only when the second half of a chip is consumed.
    b1_gold_gen u_gold (
        .clk_i      (rx_clk),
        .rst_n_i    (rx_rst_n),
        .load_i     (rx_load),
        .step_i     (tick & half_q),
        .tap_a_i    (rx_g2_tapA),
        .tap_b_i    (rx_g2_tapB),
        .chip_o     (code_chip),
        .chip_idx_o (chip_idx)
    );

    // Sample for the (chip, half) being left by this tick.
    assign new_sample = '{val:    code_chip ^ sub_term,
                          marker: (chip_idx == '0) && !half_q,
                          chip:   chip_idx};

    always_comb begin
        phase_d  = phase_q;
        half_d   = half_q;
        e_d      = e_q;
        p_val_d  = p_val_q;
        p_chip_d = p_chip_q;
        l_val_d  = l_val_q;
        sop_d    = 1'b0;
        if (rx_load) begin
            phase_d  = '0;
            half_d   = 1'b0;
            e_d      = '0;
            p_val_d  = 1'b0;
            p_chip_d = '0;
            l_val_d  = 1'b0;
        end else if (rx_enable) begin
            phase_d = phase_sum;
            if (carry) begin
                half_d   = ~half_q;
                e_d      = new_sample;
                p_val_d  = e_q.val;
                p_chip_d = e_q.chip;
                l_val_d  = p_val_q;
                // Marker moving from E into P: pulse for the following cycle.
                sop_d    = e_q.marker;
            end
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            phase_q  <= '0;
            half_q   <= 1'b0;
            e_q      <= '0;
            p_val_q  <= 1'b0;
            p_chip_q <= '0;
            l_val_q  <= 1'b0;
            sop_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            half_q   <= half_d;
            e_q      <= e_d;
            p_val_q  <= p_val_d;
            p_chip_q <= p_chip_d;
            l_val_q  <= l_val_d;
            sop_q    <= sop_d;
        end
    end

    assign tx_loc_bocE = e_q.val;
    assign tx_loc_bocP = p_val_q;
    assign tx_loc_bocL = l_val_q;
    assign tx_prn_sop  = sop_q;
    assign tx_chip_cnt = p_chip_q;

endmodule

// File: tb/tb_b1_loc_gen.sv
`timescale 1ns/1ps
module tb_b1_loc_gen;

    localparam int EPOCH  = 2046;
    localparam int HALVES = 2 * EPOCH;
`ifdef B1_LOC_BPSK_EN
    localparam bit BOC = 1'b0;
`else
    localparam bit BOC = 1'b1;
`endif

    logic        rx_clk     = 1'b0;
    logic        rx_rst_n   = 1'b0;
    logic        rx_enable  = 1'b0;
    logic        rx_load    = 1'b0;
    logic [3:0]  rx_g2_tapA = 4'd1;
    logic [3:0]  rx_g2_tapB = 4'd3;
    logic [31:0] rx_prn_fcw = 32'd0;
    logic        tx_loc_bocE, tx_loc_bocP, tx_loc_bocL, tx_prn_sop;
    logic [10:0] tx_chip_cnt;

    always #5 rx_clk = ~rx_clk;

    b1_loc_gen dut (
        .rx_clk      (rx_clk),
        .rx_rst_n    (rx_rst_n),
        .rx_enable   (rx_enable),
        .rx_load     (rx_load),
        .rx_g2_tapA  (rx_g2_tapA),
        .rx_g2_tapB  (rx_g2_tapB),
        .rx_prn_fcw  (rx_prn_fcw),
        .tx_loc_bocE (tx_loc_bocE),
        .tx_loc_bocP (tx_loc_bocP),
        .tx_loc_bocL (tx_loc_bocL),
        .tx_prn_sop  (tx_prn_sop),
        .tx_chip_cnt (tx_chip_cnt)
    );

    // ---------------- bookkeeping ----------------
    int chk_n  = 0;
    int pass_n = 0;
    int cyc    = 0;
    bit run_chk = 1'b0;
    bit dly_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    // code[] holds one truncated epoch; the replica is then a pure function
    // of the number of half-chip ticks counted since the last restart.
    bit     code [EPOCH];
    bit     g1_first;
    longint m_phase = 0;
    int     m_k     = 0;
    bit     m_sop   = 1'b0;

    function automatic logic [3:0] san(input logic [3:0] t);
        return (t == 4'd0 || t > 4'd11) ? 4'd11 : t;
    endfunction

    function automatic void build_code(input logic [3:0] ta, input logic [3:0] tb);
        logic [11:1] g1, g2;
        logic        f1, f2;
        g1 = 11'b01010101010;
        g2 = g1;
        g1_first = g1[11];
        for (int c = 0; c < EPOCH; c++) begin
            code[c] = g1[11] ^ g2[ta] ^ g2[tb];
            f1 = g1[1] ^ g1[7] ^ g1[8] ^ g1[9] ^ g1[10] ^ g1[11];
            f2 = g2[1] ^ g2[2] ^ g2[3] ^ g2[4] ^ g2[5] ^ g2[8] ^ g2[9] ^ g2[11];
            g1 = {g1[10:1], f1};
            g2 = {g2[10:1], f2};
        end
    endfunction

    // Value of the n-th half-chip since the epoch restart.
    function automatic bit hv(input int n);
        return code[(n / 2) % EPOCH] ^ (BOC && (n % 2 == 1));
    endfunction

    initial begin
        build_code(4'd1, 4'd3);
        forever begin
            @(posedge rx_clk or negedge rx_rst_n);
            if (!rx_rst_n) begin
                if (m_k != 0 || m_phase != 0) build_code(4'd1, 4'd3);
                m_phase = 0; m_k = 0; m_sop = 1'b0;
            end else if (rx_load) begin
                m_phase = 0; m_k = 0; m_sop = 1'b0;
                build_code(san(rx_g2_tapA), san(rx_g2_tapB));
            end else if (rx_enable) begin
                m_phase = m_phase + longint'(rx_prn_fcw);
                if (m_phase >= 64'sh1_0000_0000) begin
                    m_phase = m_phase - 64'sh1_0000_0000;
                    m_k++;
                    m_sop = (m_k >= 2) && ((m_k - 2) % HALVES == 0);
                end else begin
                    m_sop = 1'b0;
                end
            end else begin
                m_sop = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit e_hist [4];

    initial begin
        bit ee, ep, el;
        int cc;
        forever begin
            @(negedge rx_clk);
            cyc++;
            if (run_chk) begin
                ee = (m_k >= 1) ? hv(m_k - 1) : 1'b0;
                ep = (m_k >= 2) ? hv(m_k - 2) : 1'b0;
                el = (m_k >= 3) ? hv(m_k - 3) : 1'b0;
                cc = (m_k >= 2) ? ((m_k - 2) / 2) % EPOCH : 0;
                check("model_EPL_sop_cnt",
                      32'({tx_loc_bocE, tx_loc_bocP, tx_loc_bocL, tx_prn_sop, tx_chip_cnt}),
                      32'({ee, ep, el, m_sop, 11'(cc)}));
                if (dly_en) begin
                    check("P_is_E_delayed_2", 32'(tx_loc_bocP), 32'(e_hist[1]));
                    check("L_is_E_delayed_4", 32'(tx_loc_bocL), 32'(e_hist[3]));
                end
            end
            for (int i = 3; i >= 1; i--) e_hist[i] = e_hist[i - 1];
            e_hist[0] = tx_loc_bocE;
        end
    end

    // ---------------- directed stimulus ----------------
    // E after each cycle following a load at fcw 0x80000000, taps 1/3.
    logic [10:1] lit_e;

    task automatic do_load(input logic [3:0] ta, input logic [3:0] tb);
        rx_g2_tapA = ta;
        rx_g2_tapB = tb;
        rx_load    = 1'b1;
        @(negedge rx_clk);
        rx_load    = 1'b0;
    endtask

    task automatic literal_after_load(input string tag);
        for (int j = 1; j <= 10; j++) begin
            @(negedge rx_clk);
            check({tag, "_E"}, 32'(tx_loc_bocE), 32'(lit_e[j]));
            if (j == 4)  check({tag, "_first_sop"}, 32'(tx_prn_sop), 32'd1);
            if (j == 10) check({tag, "_chip_cnt"}, 32'(tx_chip_cnt), 32'd1);
        end
    endtask

    initial begin
        int n;
        lit_e = BOC ? 10'b1001111000 : 10'b1111100000;

        // Reset state
        repeat (2) @(negedge rx_clk);
        run_chk = 1'b1;
        @(negedge rx_clk);
        check("reset_outputs",
              32'({tx_loc_bocE, tx_loc_bocP, tx_loc_bocL, tx_prn_sop, tx_chip_cnt}), 32'd0);
        rx_rst_n = 1'b1;

        // Taps 1/3, half-chip tick every 2 cycles
        @(negedge rx_clk);
        rx_enable  = 1'b1;
        rx_prn_fcw = 32'h8000_0000;
        do_load(4'd1, 4'd3);
        check("model_g1_first_bit", 32'(g1_first), 32'd0);
        check("model_code_0_1_2", 32'({code[0], code[1], code[2]}), 32'b011);
        check("load_chip_cnt", 32'(tx_chip_cnt), 32'd0);
        literal_after_load("start");
        dly_en = 1'b1;

        // Epoch period: first sop was 6 cycles ago
        n = 6;
        while (!tx_prn_sop && n < 9000) begin
            @(negedge rx_clk);
            n++;
        end
        check("sop_period", 32'(n), 32'd8184);
        check("wrap_chip_cnt", 32'(tx_chip_cnt), 32'd0);
        repeat (200) @(negedge rx_clk);
        dly_en = 1'b0;

        // Freeze mid-epoch
        rx_enable = 1'b0;
        repeat (100) @(negedge rx_clk);
        rx_enable = 1'b1;
        repeat (600) @(negedge rx_clk);

        // Load coincident with the tick that ends chip 1000
        do_load(4'd1, 4'd3);
        n = 0;
        while (!(m_k == 2001 && m_phase == 64'sh8000_0000) && n < 10000) begin
            @(negedge rx_clk);
            n++;
        end
        check("reach_chip_1000", 32'(m_k), 32'd2001);
        do_load(4'd1, 4'd3);
        check("coinc_load_chip_cnt", 32'(tx_chip_cnt), 32'd0);
        check("coinc_load_EPL", 32'({tx_loc_bocE, tx_loc_bocP, tx_loc_bocL}), 32'd0);
        literal_after_load("coinc");

        // NCO extremes and an arbitrary rate
        rx_prn_fcw = 32'hFFFF_FFFF;
        repeat (300) @(negedge rx_clk);
        rx_prn_fcw = 32'd0;
        repeat (50) @(negedge rx_clk);
        rx_prn_fcw = 32'h1234_5678;
        repeat (600) @(negedge rx_clk);

        // Illegal taps -> stage 11, full epoch at maximum rate
        rx_prn_fcw = 32'hFFFF_FFFF;
        do_load(4'd0, 4'd12);
        repeat (4200) @(negedge rx_clk);

        // Asynchronous reset mid-epoch
        #2 rx_rst_n = 1'b0;
        #1 check("async_reset_outputs",
                 32'({tx_loc_bocE, tx_loc_bocP, tx_loc_bocL, tx_prn_sop, tx_chip_cnt}), 32'd0);
        @(negedge rx_clk);
        @(negedge rx_clk);
        rx_rst_n = 1'b1;
        repeat (300) @(negedge rx_clk);

        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule
